// File: rtl/ppfifo_write_arbiter_if.sv
// Requester-side and PPFIFO-side write signals of the two-way PPFIFO write arbiter.
// The slave modport faces the arbiter; the master modport faces requesters and the FIFO.
interface ppfifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req0_req;
    logic [1:0]            o_req0_rdy;
    logic [1:0]            i_req0_act;
    logic [23:0]           o_req0_size;
    logic                  i_req0_stb;
    logic [DATA_WIDTH:0]   i_req0_data;

    logic                  i_req1_req;
    logic [1:0]            o_req1_rdy;
    logic [1:0]            i_req1_act;
    logic [23:0]           o_req1_size;
    logic                  i_req1_stb;
    logic [DATA_WIDTH:0]   i_req1_data;

    logic [1:0]            i_ppfifo_rdy;
    logic [1:0]            o_ppfifo_act;
    logic [23:0]           i_ppfifo_size;
    logic                  o_ppfifo_stb;
    logic [DATA_WIDTH:0]   o_ppfifo_data;

    logic [1:0]            o_grant;
    logic                  o_overflow;

    modport slave (
        input  i_req0_req, i_req0_act, i_req0_stb, i_req0_data,
        input  i_req1_req, i_req1_act, i_req1_stb, i_req1_data,
        input  i_ppfifo_rdy, i_ppfifo_size,
        output o_req0_rdy, o_req0_size, o_req1_rdy, o_req1_size,
        output o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data, o_grant, o_overflow
    );

    modport master (
        output i_req0_req, i_req0_act, i_req0_stb, i_req0_data,
        output i_req1_req, i_req1_act, i_req1_stb, i_req1_data,
        output i_ppfifo_rdy, i_ppfifo_size,
        input  o_req0_rdy, o_req0_size, o_req1_rdy, o_req1_size,
        input  o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data, o_grant, o_overflow
    );
endinterface

// File: rtl/ppfifo_write_arbiter.sv
// Round-robin arbiter sharing one PPFIFO write port between two requesters.
// Optional grant timeout (o_timeout, TIMEOUT) is built when PPFIFO_ARB_TIMEOUT_EN is defined.
module ppfifo_write_arbiter #(
    parameter int DATA_WIDTH = 32
`ifdef PPFIFO_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic clk,
    input  logic rst,
`ifdef PPFIFO_ARB_TIMEOUT_EN
    output logic o_timeout,
`endif
    ppfifo_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, RELEASE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               req;
    logic [1:0][1:0]          act_in;
    logic [1:0]               stb_in;
    logic [1:0][DATA_WIDTH:0] data_in;

    logic                     ptr_q, ptr_d;
    logic                     win_q, win_d;
    logic [1:0]               act_q, act_d;
    logic [1:0]               grant_q, grant_d;
    logic [1:0][1:0]          rdy_q, rdy_d;
    logic                     stb_q, stb_d;
    logic                     ovf_q, ovf_d;
    logic [DATA_WIDTH:0]      data_q, data_d;
    logic [23:0]              cnt_q, cnt_d;

    logic                     pick, pick_buf;
    logic                     w_act, w_stb;
    logic [DATA_WIDTH:0]      w_data;

`ifdef PPFIFO_ARB_TIMEOUT_EN
    logic [31:0]              tmo_q, tmo_d;
    logic                     tmo_pulse_q, tmo_pulse_d;
`endif

    assign req     = {bus.i_req1_req, bus.i_req0_req};
    assign act_in  = {bus.i_req1_act, bus.i_req0_act};
    assign stb_in  = {bus.i_req1_stb, bus.i_req0_stb};
    assign data_in = {bus.i_req1_data, bus.i_req0_data};

    // Pointed-to requester wins ties; buffer 0 preferred whenever it is ready.
    assign pick     = req[ptr_q] ? ptr_q : ~ptr_q;
    assign pick_buf = ~bus.i_ppfifo_rdy[0];

    // Only the current owner's controls are ever looked at.
    assign w_act  = |act_in[win_q];
    assign w_stb  = stb_in[win_q];
    assign w_data = data_in[win_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        act_d   = act_q;
        grant_d = grant_q;
        rdy_d   = rdy_q;
        stb_d   = 1'b0;
        ovf_d   = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef PPFIFO_ARB_TIMEOUT_EN
        tmo_d       = '0;
        tmo_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if ((|bus.i_ppfifo_rdy) && (|req)) begin
                    win_d                 = pick;
                    act_d                 = '0;
                    act_d[pick_buf]       = 1'b1;
                    grant_d               = '0;
                    grant_d[pick]         = 1'b1;
                    rdy_d                 = '0;
                    rdy_d[pick][pick_buf] = 1'b1;
                    cnt_d                 = '0;
                    state_d               = GRANT;
                end
            end
            GRANT: begin
`ifdef PPFIFO_ARB_TIMEOUT_EN
                tmo_d = tmo_q + 32'd1;
`endif
                if (w_act) begin
                    rdy_d   = '0;
                    state_d = ACTIVE;
                end
`ifdef PPFIFO_ARB_TIMEOUT_EN
                else if (tmo_q == 32'(TIMEOUT - 1)) begin
                    rdy_d       = '0;
                    tmo_pulse_d = 1'b1;
                    state_d     = RELEASE;
                end
`endif
            end
            ACTIVE: begin
                // A strobe alongside the act release belongs to no burst.
                if (!w_act) begin
                    state_d = RELEASE;
                end else if (w_stb) begin
                    if (cnt_q < bus.i_ppfifo_size) begin
                        stb_d  = 1'b1;
                        data_d = w_data;
                        cnt_d  = cnt_q + 24'd1;
                    end else begin
                        ovf_d  = 1'b1;
                    end
                end
            end
            RELEASE: begin
                act_d   = '0;
                grant_d = '0;
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            act_q   <= '0;
            grant_q <= '0;
            rdy_q   <= '0;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef PPFIFO_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            act_q   <= act_d;
            grant_q <= grant_d;
            rdy_q   <= rdy_d;
            stb_q   <= stb_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef PPFIFO_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            tmo_pulse_q <= tmo_pulse_d;
`endif
        end
    end

    assign bus.o_req0_rdy    = rdy_q[0];
    assign bus.o_req1_rdy    = rdy_q[1];
    assign bus.o_req0_size   = bus.i_ppfifo_size;
    assign bus.o_req1_size   = bus.i_ppfifo_size;
    assign bus.o_ppfifo_act  = act_q;
    assign bus.o_ppfifo_stb  = stb_q;
    assign bus.o_ppfifo_data = data_q;
    assign bus.o_grant       = grant_q;
    assign bus.o_overflow    = ovf_q;
`ifdef PPFIFO_ARB_TIMEOUT_EN
    assign o_timeout = tmo_pulse_q;
`endif
endmodule

// File: tb/tb_ppfifo_write_arbiter.sv
// Randomized bench for ppfifo_write_arbiter: a burst-level protocol model predicts every
// output per cycle; directed bursts pin winners, strobe and overflow counts.
module tb_ppfifo_write_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppfifo_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef PPFIFO_ARB_TIMEOUT_EN
    logic o_timeout;
    logic nxt_tmo, exp_tmo;
    ppfifo_write_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .o_timeout(o_timeout), .bus(bus));
`else
    ppfifo_write_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // stimulus
    logic [1:0]  t_req, t_stb, t_prdy;
    logic [1:0]  t_act [2];
    logic [DW:0] t_data [2];
    logic [23:0] t_size;

    assign bus.i_req0_req    = t_req[0];
    assign bus.i_req1_req    = t_req[1];
    assign bus.i_req0_act    = t_act[0];
    assign bus.i_req1_act    = t_act[1];
    assign bus.i_req0_stb    = t_stb[0];
    assign bus.i_req1_stb    = t_stb[1];
    assign bus.i_req0_data   = t_data[0];
    assign bus.i_req1_data   = t_data[1];
    assign bus.i_ppfifo_rdy  = t_prdy;
    assign bus.i_ppfifo_size = t_size;

    // model: nxt_* is what the outputs must be after the coming edge
    logic [1:0]  nxt_act, nxt_grant, exp_act, exp_grant;
    logic [1:0]  nxt_rdy [2];
    logic [1:0]  exp_rdy [2];
    logic        nxt_stb, nxt_ovf, exp_stb, exp_ovf;
    logic [DW:0] nxt_data, exp_data;
    int          ptr;
    bit          chk_en;
    int          tests, fails, dut_stb_cnt, dut_ovf_cnt;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_act    <= nxt_act;
        exp_grant  <= nxt_grant;
        exp_rdy[0] <= nxt_rdy[0];
        exp_rdy[1] <= nxt_rdy[1];
        exp_stb    <= nxt_stb;
        exp_ovf    <= nxt_ovf;
        exp_data   <= nxt_data;
`ifdef PPFIFO_ARB_TIMEOUT_EN
        exp_tmo    <= nxt_tmo;
`endif
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ppfifo_stb === 1'b1) dut_stb_cnt++;
            if (bus.o_overflow === 1'b1) dut_ovf_cnt++;
        end
        if (chk_en && !rst) begin
            chk("ppfifo_act", 64'(bus.o_ppfifo_act), 64'(exp_act));
            chk("grant", 64'(bus.o_grant), 64'(exp_grant));
            chk("req0_rdy", 64'(bus.o_req0_rdy), 64'(exp_rdy[0]));
            chk("req1_rdy", 64'(bus.o_req1_rdy), 64'(exp_rdy[1]));
            chk("ppfifo_stb", 64'(bus.o_ppfifo_stb), 64'(exp_stb));
            chk("overflow", 64'(bus.o_overflow), 64'(exp_ovf));
            chk("ppfifo_data", 64'(bus.o_ppfifo_data), 64'(exp_data));
            chk("req0_size", 64'(bus.o_req0_size), 64'(t_size));
            chk("req1_size", 64'(bus.o_req1_size), 64'(t_size));
`ifdef PPFIFO_ARB_TIMEOUT_EN
            chk("timeout", 64'(o_timeout), 64'(exp_tmo));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input int l, input bit en);
        t_stb[l]  = en ? 1'($urandom_range(1)) : 1'b0;
        t_act[l]  = en ? 2'($urandom_range(3)) : 2'b00;
        t_data[l] = {1'($urandom_range(1)), 32'($urandom)};
    endtask

    task automatic clear_all();
        t_req = '0; t_stb = '0; t_act[0] = '0; t_act[1] = '0;
        nxt_act = '0; nxt_grant = '0; nxt_rdy[0] = '0; nxt_rdy[1] = '0;
        nxt_stb = 1'b0; nxt_ovf = 1'b0;
`ifdef PPFIFO_ARB_TIMEOUT_EN
        nxt_tmo = 1'b0;
`endif
    endtask

    task automatic idle(input int k);
        clear_all();
        repeat (k) step();
    endtask

    // One whole burst seen from the requesters' side. abort_at >= 0 resets the
    // design after that many strobes instead of finishing the burst.
    task automatic burst(input logic [1:0] reqm, input logic [1:0] rdyv, input int sz,
                         input int n, input bit wrong, input bit nz, input int maxgap,
                         input bit seqd, input int abort_at, output int win, output int nacc);
        int w, b, l;
        w = reqm[ptr] ? ptr : 1 - ptr;
        b = rdyv[0] ? 0 : 1;
        l = 1 - w;
        win = w; nacc = 0;
        t_req = reqm; t_prdy = rdyv; t_size = 24'(sz);
        t_act[w] = '0; t_stb[w] = 1'b0;
        noise(l, 1'b0);
        nxt_grant = 2'(1 << w); nxt_act = 2'(1 << b);
        nxt_rdy[w] = 2'(1 << b); nxt_rdy[l] = '0;
        nxt_stb = 1'b0; nxt_ovf = 1'b0;
        step();
        repeat ($urandom_range(maxgap)) begin noise(l, nz); step(); end
        t_act[w] = wrong ? 2'(1 << (1 - b)) : 2'(1 << b);
        nxt_rdy[w] = '0;
        noise(l, nz); step();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                t_stb[w] = 1'b0; nxt_stb = 1'b0; nxt_ovf = 1'b0;
                step();
                chk_en = 0;
                #2 rst = 1'b1;
                #1;
                chk("rst_ppfifo_act", 64'(bus.o_ppfifo_act), 64'd0);
                chk("rst_grant", 64'(bus.o_grant), 64'd0);
                chk("rst_req0_rdy", 64'(bus.o_req0_rdy), 64'd0);
                chk("rst_req1_rdy", 64'(bus.o_req1_rdy), 64'd0);
                chk("rst_ppfifo_stb", 64'(bus.o_ppfifo_stb), 64'd0);
                clear_all();
                nxt_data = '0;
                noise(0, 1'b0); noise(1, 1'b0);
                step(); step();
                rst = 1'b0;
                step();
                chk_en = 1;
                ptr = 0;
                return;
            end
            repeat ($urandom_range(maxgap)) begin
                t_stb[w] = 1'b0; nxt_stb = 1'b0; nxt_ovf = 1'b0;
                noise(l, nz); step();
            end
            t_stb[w]  = 1'b1;
            t_data[w] = seqd ? (DW+1)'(i) : {1'($urandom_range(1)), 32'($urandom)};
            if (nacc < sz) begin
                nxt_stb = 1'b1; nxt_ovf = 1'b0; nxt_data = t_data[w]; nacc++;
            end else begin
                nxt_stb = 1'b0; nxt_ovf = 1'b1;
            end
            noise(l, nz); step();
        end
        // a strobe alongside the act release must be ignored
        t_act[w] = '0; t_stb[w] = 1'($urandom_range(1));
        nxt_stb = 1'b0; nxt_ovf = 1'b0;
        noise(l, nz); step();
        t_stb[w] = 1'b0;
        nxt_act = '0; nxt_grant = '0;
        noise(l, nz); step();
        ptr = l;
        noise(l, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, w3, na, s0, o0, tot;
        tests = 0; fails = 0; dut_stb_cnt = 0; dut_ovf_cnt = 0;
        chk_en = 0; ptr = 0;
        rst = 1'b1;
        t_prdy = '0; t_size = '0; t_data[0] = '0; t_data[1] = '0;
        clear_all();
        nxt_data = '0;
        #1;
        chk("reset_ppfifo_act", 64'(bus.o_ppfifo_act), 64'd0);
        chk("reset_grant", 64'(bus.o_grant), 64'd0);
        chk("reset_ppfifo_stb", 64'(bus.o_ppfifo_stb), 64'd0);
        chk("reset_overflow", 64'(bus.o_overflow), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk_en = 1;

        // request pending, no downstream buffer: nothing happens
        t_req = 2'b01; t_prdy = 2'b00;
        repeat (3) step();

        // single requester, 4 words 0..3 into a size-4 buffer
        s0 = dut_stb_cnt;
        burst(2'b01, 2'b01, 4, 4, 1'b0, 1'b0, 0, 1'b1, -1, w1, na);
        chk("single_winner", 64'(w1), 64'd0);
        chk("single_stb_count", 64'(dut_stb_cnt - s0), 64'd4);
        idle(2);

        // reset after 2 accepted words of requester 1
        s0 = dut_stb_cnt;
        burst(2'b10, 2'b11, 8, 5, 1'b0, 1'b1, 1, 1'b0, 2, w1, na);
        idle(3);
        chk("reset_burst_stb_count", 64'(dut_stb_cnt - s0), 64'd2);

        // both requesting, three back-to-back bursts, loser strobing throughout
        s0 = dut_stb_cnt; tot = 0;
        burst(2'b11, 2'b11, 6, 3, 1'b0, 1'b1, 2, 1'b0, -1, w1, na); tot += na;
        burst(2'b11, 2'b11, 6, 4, 1'b1, 1'b1, 2, 1'b0, -1, w2, na); tot += na;
        burst(2'b11, 2'b11, 6, 2, 1'b0, 1'b1, 2, 1'b0, -1, w3, na); tot += na;
        chk("rr_winner_0", 64'(w1), 64'd0);
        chk("rr_winner_1", 64'(w2), 64'd1);
        chk("rr_winner_2", 64'(w3), 64'd0);
        chk("rr_stb_count", 64'(dut_stb_cnt - s0), 64'(tot));
        idle(1);

        // 6 strobes into a size-4 buffer (buffer 1)
        s0 = dut_stb_cnt; o0 = dut_ovf_cnt;
        burst(2'b01, 2'b10, 4, 6, 1'b0, 1'b1, 1, 1'b0, -1, w1, na);
        chk("ovf_stb_count", 64'(dut_stb_cnt - s0), 64'd4);
        chk("ovf_pulse_count", 64'(dut_ovf_cnt - o0), 64'd2);

        // zero-length burst
        s0 = dut_stb_cnt;
        burst(2'b10, 2'b01, 4, 0, 1'b0, 1'b1, 1, 1'b0, -1, w1, na);
        chk("zero_len_stb_count", 64'(dut_stb_cnt - s0), 64'd0);

        // size 0: every strobe overflows
        o0 = dut_ovf_cnt;
        burst(2'b11, 2'b11, 0, 3, 1'b0, 1'b0, 0, 1'b0, -1, w1, na);
        chk("size0_ovf_count", 64'(dut_ovf_cnt - o0), 64'd3);

        for (int k = 0; k < 40; k++) begin
            burst(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), $urandom_range(0, 6),
                  $urandom_range(0, 8), 1'($urandom_range(1)), 1'b1, 3, 1'b0, -1, w1, na);
            if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
        end

`ifdef PPFIFO_ARB_TIMEOUT_EN
        // winner never activates: grant expires on the 8th GRANT edge
        idle(1);
        w1 = ptr;
        t_req = 2'b11; t_prdy = 2'b11;
        nxt_grant = 2'(1 << w1); nxt_act = 2'b01; nxt_rdy[w1] = 2'b01;
        step();
        repeat (7) step();
        nxt_rdy[w1] = '0; nxt_tmo = 1'b1;
        step();
        nxt_tmo = 1'b0; nxt_act = '0; nxt_grant = '0;
        step();
        ptr = 1 - w1;
        burst(2'b11, 2'b11, 4, 2, 1'b0, 1'b0, 0, 1'b0, -1, w2, na);
        chk("timeout_next_winner", 64'(w2), 64'(1 - w1));
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ppfifo_write_arbiter.md
Name: ppfifo_write_arbiter

Overview:
- Shares one Ping Pong FIFO write port between two requesters. Each requester, typically an AXI-stream-to-PPFIFO adapter, sees a standard PPFIFO write-controller interface.
- Grants one downstream buffer to one requester at a time, using round-robin priority.
- Sits between the stream adapters and the PPFIFO write side, for example to merge command and pixel streams into the TFT FIFO.

Parameters:
- DATA_WIDTH, 32, payload width. Every data bus is DATA_WIDTH+1 wide; the MSB is the last flag.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_reqN_req  in  1  (N=0,1) requester N has data pending and wants a buffer.
- o_reqN_rdy  out  2  (N=0,1) virtual PPFIFO ready presented to requester N.
- i_reqN_act  in  2  (N=0,1) requester N activate.
- o_reqN_size  out  24  (N=0,1) copy of i_ppfifo_size, combinational.
- i_reqN_stb  in  1  (N=0,1) requester N write strobe.
- i_reqN_data  in  DATA_WIDTH+1  (N=0,1) requester N write data.
- i_ppfifo_rdy  in  2  downstream buffer ready.
- o_ppfifo_act  out  2  downstream activate.
- i_ppfifo_size  in  24  downstream buffer size in words.
- o_ppfifo_stb  out  1  downstream write strobe.
- o_ppfifo_data  out  DATA_WIDTH+1  downstream write data.
- o_grant  out  2  one-hot current owner; 0 when idle.
- o_overflow  out  1  one-cycle pulse when a strobe beyond the buffer size is dropped.

Behaviour:
- Reset (asynchronous, active-high): all registered outputs are 0, state is IDLE, priority pointer selects requester 0, word count is 0.
- State machine: IDLE -> GRANT -> ACTIVE -> RELEASE -> IDLE.
- IDLE:
  - Wait until i_ppfifo_rdy!=0 and any i_reqN_req=1.
  - Winner: the pointed-to requester if its req is set, otherwise the other one.
  - Buffer: bit 0 if i_ppfifo_rdy[0], else bit 1.
  - Register o_ppfifo_act[buf]=1, o_grant=winner, word count=0, then go to GRANT.
  - Simultaneous requests are resolved by the pointer.
- GRANT:
  - o_reqW_rdy[buf]=1 for the winner only; the loser's rdy stays 0.
  - When i_reqW_act!=0: clear o_reqW_rdy and go to ACTIVE.
  - Requester act on the wrong bit is treated as the granted buffer.
  - The non-winner's act, stb and data are ignored in every state.
- ACTIVE:
  - Each winner i_reqW_stb with i_reqW_act!=0 and count<i_ppfifo_size is registered through: o_ppfifo_stb=1 and o_ppfifo_data=i_reqW_data one cycle later; count increments.
  - A strobe with count>=i_ppfifo_size is dropped and pulses o_overflow one cycle later.
  - When i_reqW_act==0, go to RELEASE.
  - A strobe presented in the same cycle as act==0 is ignored.
- RELEASE:
  - o_ppfifo_act=0 at the next edge, o_grant=0, and the pointer is set to the requester that did not just win. Then go to IDLE.
  - Downstream act therefore stays high for at least one cycle after the final o_ppfifo_stb.
  - A zero-length burst (act released with count 0) is legal and passed through.
- o_ppfifo_stb is 0 in every state except the cycle after an accepted strobe.
- o_ppfifo_data holds its last value when stb is 0.
- Count is 24 bits with no wrap; the size check guarantees count<=size.
- Reset mid-burst: all acts and rdys go to 0 immediately. No further strobes are issued.

Optional Feature:
- Macro PPFIFO_ARB_TIMEOUT_EN.
- When defined: an additional parameter TIMEOUT (default 1024) applies in GRANT. If the winner has not asserted act within TIMEOUT cycles, go to RELEASE: drop o_reqW_rdy and o_ppfifo_act, advance the pointer, and pulse o_timeout (1-bit output, present only with the macro) for one cycle.
- When undefined: GRANT waits indefinitely, and neither o_timeout nor TIMEOUT exists.

Test Plan:
- Single requester, req0=1, rdy=01, size=4, 4 strobes with data 0..3 -> o_ppfifo_act=01; stb on 4 cycles, each one cycle after its input strobe; data 0..3; act drops 2 cycles after req act drops; o_grant returns to 0.
- Both req set together, three back-to-back bursts, rdy always 11 -> winners are 0, 1, 0; buffers chosen are bit 0 each time.
- Requester strobes 6 words with size=4 -> exactly 4 downstream strobes; o_overflow pulses twice.
- Reset asserted during ACTIVE after 2 words -> o_ppfifo_act, o_reqN_rdy and o_grant are 0 asynchronously; no stb afterwards; the next burst is granted to requester 0.
- Loser strobing during the other requester's burst -> zero downstream effect; word count is unchanged.
- (PPFIFO_ARB_TIMEOUT_EN, TIMEOUT=8) winner never asserts act -> o_timeout pulses on cycle 8 of GRANT; the other pending requester is granted next.
